// File: rtl/btb_assoc_if.sv
// Bundle of the fetch-lookup, EX-update and flush signals of the branch target buffer.
// master drives lookups/updates/flush; slave is the BTB itself.
interface btb_assoc_if;
   logic [31:0] pc_if;
   logic        hit_if;
   logic [31:0] target_if;
   logic        upd_en;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic        flush_req;
   logic        flush_busy;

   modport master (
      output pc_if, upd_en, upd_pc, upd_target, upd_taken, flush_req,
      input  hit_if, target_if, flush_busy
   );

   modport slave (
      input  pc_if, upd_en, upd_pc, upd_target, upd_taken, flush_req,
      output hit_if, target_if, flush_busy
   );
endinterface

// File: rtl/btb_assoc.sv
// N-way set-associative branch target buffer with per-set round-robin replacement and a one-set-per-cycle flush sweep.
// Define BTB_HYST_EN to add a 2-bit saturating taken counter per entry.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | lookups and updates active
// ST_SWEEP | invalidating set ptr_q each cycle; lookups miss, updates dropped
module btb_assoc #(
   parameter int ENTRIES = 256,
   parameter int WAYS    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   btb_assoc_if.slave  bus
);
   localparam int SETS  = ENTRIES / WAYS;
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 32 - IDX_W - 2;
   localparam int SET_W = (IDX_W > 0) ? IDX_W : 1;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic {ST_IDLE, ST_SWEEP} state_e;

   function automatic logic [SET_W-1:0] set_of(input logic [31:0] pc);
      return SET_W'((pc >> 2) & 32'(SETS - 1));
   endfunction

   function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc);
      return TAG_W'(pc >> (IDX_W + 2));
   endfunction

   state_e            state_q, state_d;
   logic [SET_W-1:0]  ptr_q, ptr_d;
   logic [WAYS-1:0]   valid_q [SETS];
   logic [WAYS-1:0]   valid_d [SETS];
   logic [WAY_W-1:0]  rr_q    [SETS];
   logic [WAY_W-1:0]  rr_d    [SETS];
   logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
   logic [TAG_W-1:0]  tag_d   [SETS][WAYS];
   logic [31:0]       target_q[SETS][WAYS];
   logic [31:0]       target_d[SETS][WAYS];
`ifdef BTB_HYST_EN
   logic [1:0]        ctr_q   [SETS][WAYS];
   logic [1:0]        ctr_d   [SETS][WAYS];
`endif

   logic [SET_W-1:0]  lk_set;
   logic [TAG_W-1:0]  lk_tag;
   logic              lk_pred;
   logic              lk_hit;
   logic [31:0]       lk_target;

   always_comb begin
      lk_set    = set_of(bus.pc_if);
      lk_tag    = tag_of(bus.pc_if);
      lk_pred   = 1'b0;
      lk_hit    = 1'b0;
      lk_target = '0;
      for (int w = 0; w < WAYS; w++) begin
`ifdef BTB_HYST_EN
         lk_pred = ctr_q[lk_set][w][1];
`else
         lk_pred = 1'b1;
`endif
         if (valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag) && lk_pred) begin
            lk_hit    = 1'b1;
            lk_target = target_q[lk_set][w];
         end
      end
   end

   assign bus.flush_busy = (state_q == ST_SWEEP);
   assign bus.hit_if     = lk_hit && (state_q != ST_SWEEP);
   assign bus.target_if  = bus.hit_if ? lk_target : 32'd0;

   logic [SET_W-1:0]  up_set;
   logic [TAG_W-1:0]  up_tag;
   logic              up_hit;
   logic [WAY_W-1:0]  up_hit_way;
   logic              inv_found;
   logic [WAY_W-1:0]  inv_way;
   logic [WAY_W-1:0]  alloc_way;

   always_comb begin
      up_set     = set_of(bus.upd_pc);
      up_tag     = tag_of(bus.upd_pc);
      up_hit     = 1'b0;
      up_hit_way = '0;
      inv_found  = 1'b0;
      inv_way    = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[up_set][w] && (tag_q[up_set][w] == up_tag)) begin
            up_hit     = 1'b1;
            up_hit_way = WAY_W'(w);
         end
      end
      // descending scan so the lowest-index invalid way is the one left standing
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[up_set][w]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
      alloc_way = inv_found ? inv_way : rr_q[up_set];
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      valid_d  = valid_q;
      rr_d     = rr_q;
      tag_d    = tag_q;
      target_d = target_q;
`ifdef BTB_HYST_EN
      ctr_d    = ctr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.flush_req) begin
               state_d = ST_SWEEP;
               ptr_d   = '0;
            end else if (bus.upd_en) begin
               if (up_hit) begin
`ifdef BTB_HYST_EN
                  if (bus.upd_taken) begin
                     target_d[up_set][up_hit_way] = bus.upd_target;
                     if (ctr_q[up_set][up_hit_way] != 2'd3)
                        ctr_d[up_set][up_hit_way] = ctr_q[up_set][up_hit_way] + 2'd1;
                  end else if (ctr_q[up_set][up_hit_way] != 2'd0) begin
                     ctr_d[up_set][up_hit_way] = ctr_q[up_set][up_hit_way] - 2'd1;
                  end
`else
                  if (bus.upd_taken)
                     target_d[up_set][up_hit_way] = bus.upd_target;
                  else
                     valid_d[up_set][up_hit_way] = 1'b0;
`endif
               end else if (bus.upd_taken) begin
                  valid_d[up_set][alloc_way]  = 1'b1;
                  tag_d[up_set][alloc_way]    = up_tag;
                  target_d[up_set][alloc_way] = bus.upd_target;
`ifdef BTB_HYST_EN
                  ctr_d[up_set][alloc_way]    = 2'd2;
`endif
                  if (!inv_found && (WAYS > 1))
                     rr_d[up_set] = rr_q[up_set] + WAY_W'(1);
               end
            end
         end
         ST_SWEEP: begin
            valid_d[ptr_q] = '0;
            rr_d[ptr_q]    = '0;
            if (ptr_q == SET_W'(SETS - 1)) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + SET_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            rr_q[s]    <= '0;
         end
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         rr_q    <= rr_d;
      end
   end

   // payload is qualified by valid, so it carries no reset
   always_ff @(posedge clk) begin
      tag_q    <= tag_d;
      target_q <= target_d;
`ifdef BTB_HYST_EN
      ctr_q    <= ctr_d;
`endif
   end
endmodule

// File: tb/tb_btb_assoc.sv
// Randomised and directed bench for btb_assoc against a table-level model of the BTB.
// Works in both BTB_HYST_EN builds.
module tb_btb_assoc;
   localparam int ENTRIES = 256;
   localparam int WAYS    = 2;
   localparam int SETS    = ENTRIES / WAYS;
   localparam int IDX_W   = 7;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   btb_assoc_if bus();

   btb_assoc #(.ENTRIES(ENTRIES), .WAYS(WAYS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   bit          m_v   [SETS][WAYS];
   logic [31:0] m_key [SETS][WAYS];
   logic [31:0] m_tgt [SETS][WAYS];
   int          m_ctr [SETS][WAYS];
   int          m_rr  [SETS];
   int          m_busy;

   function automatic int m_set(input logic [31:0] pc);
      return int'((pc >> 2) % SETS);
   endfunction

   function automatic logic [31:0] m_keyof(input logic [31:0] pc);
      return pc >> (IDX_W + 2);
   endfunction

   task automatic m_clear();
      for (int s = 0; s < SETS; s++) begin
         m_rr[s] = 0;
         for (int w = 0; w < WAYS; w++) m_v[s][w] = 1'b0;
      end
   endtask

   task automatic m_lookup(input logic [31:0] pc, output bit hit, output logic [31:0] tgt);
      int s;
      hit = 1'b0;
      tgt = 32'd0;
      if (m_busy > 0) return;
      s = m_set(pc);
      for (int w = 0; w < WAYS; w++) begin
         if (m_v[s][w] && m_key[s][w] == m_keyof(pc)) begin
`ifdef BTB_HYST_EN
            if (m_ctr[s][w] >= 2) begin
               hit = 1'b1;
               tgt = m_tgt[s][w];
            end
`else
            hit = 1'b1;
            tgt = m_tgt[s][w];
`endif
         end
      end
   endtask

   task automatic m_update(input logic [31:0] pc, input logic [31:0] tgt, input bit taken);
      int s;
      int way;
      s   = m_set(pc);
      way = -1;
      for (int w = 0; w < WAYS; w++)
         if (m_v[s][w] && m_key[s][w] == m_keyof(pc)) way = w;
      if (way >= 0) begin
`ifdef BTB_HYST_EN
         if (taken) begin
            m_tgt[s][way] = tgt;
            m_ctr[s][way] = (m_ctr[s][way] < 3) ? m_ctr[s][way] + 1 : 3;
         end else begin
            m_ctr[s][way] = (m_ctr[s][way] > 0) ? m_ctr[s][way] - 1 : 0;
         end
`else
         if (taken) m_tgt[s][way] = tgt;
         else       m_v[s][way]   = 1'b0;
`endif
      end else if (taken) begin
         for (int w = WAYS - 1; w >= 0; w--)
            if (!m_v[s][w]) way = w;
         if (way < 0) begin
            way     = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % WAYS;
         end
         m_v[s][way]   = 1'b1;
         m_key[s][way] = m_keyof(pc);
         m_tgt[s][way] = tgt;
         m_ctr[s][way] = 2;
      end
   endtask

   task automatic m_edge();
      if (!rst_n) return;
      if (m_busy > 0) begin
         m_busy--;
         return;
      end
      if (bus.flush_req) begin
         m_clear();
         m_busy = SETS;
         return;
      end
      if (bus.upd_en) m_update(bus.upd_pc, bus.upd_target, bus.upd_taken);
   endtask

   task automatic tick();
      @(posedge clk);
      m_edge();
      #1;
   endtask

   task automatic drive_upd(input logic [31:0] pc, input logic [31:0] tgt, input bit taken);
      bus.upd_en     = 1'b1;
      bus.upd_pc     = pc;
      bus.upd_target = tgt;
      bus.upd_taken  = taken;
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      bus.pc_if      = 32'h100;
      bus.upd_en     = 1'b0;
      bus.upd_pc     = 32'd0;
      bus.upd_target = 32'd0;
      bus.upd_taken  = 1'b0;
      bus.flush_req  = 1'b0;
      m_clear();
      m_busy = 0;
      #12;
      checks++;
      if (bus.hit_if !== 1'b0) begin
         errors++;
         $display("FAIL reset_hit got=%b want=0", bus.hit_if);
      end
      checks++;
      if (bus.target_if !== 32'd0) begin
         errors++;
         $display("FAIL reset_target got=%h want=0", bus.target_if);
      end
      checks++;
      if (bus.flush_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy got=%b want=0", bus.flush_busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      bus.pc_if = 32'h100;
      drive_upd(32'h100, 32'h2000, 1'b1);
      #3;
      checks++;
      if (bus.hit_if !== 1'b0) begin
         errors++;
         $display("FAIL same_cycle_hit got=%b want=0", bus.hit_if);
      end
      tick();
      bus.upd_en = 1'b0;
      #3;
      checks++;
      if (bus.hit_if !== 1'b1 || bus.target_if !== 32'h2000) begin
         errors++;
         $display("FAIL basic_hit got=%b/%h want=1/00002000", bus.hit_if, bus.target_if);
      end
   endtask

   task automatic test_evict();
      logic [31:0] pcs  [3] = '{32'h100, 32'h300, 32'h500};
      bit          hits [3] = '{1'b0, 1'b1, 1'b1};
      logic [31:0] tgts [3] = '{32'h0, 32'h3000, 32'h5000};
      drive_upd(32'h300, 32'h3000, 1'b1);
      tick();
      drive_upd(32'h500, 32'h5000, 1'b1);
      tick();
      bus.upd_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.pc_if = pcs[i];
         #1;
         checks++;
         if (bus.hit_if !== hits[i] || bus.target_if !== tgts[i]) begin
            errors++;
            $display("FAIL evict_%h got=%b/%h want=%b/%h", pcs[i], bus.hit_if, bus.target_if, hits[i], tgts[i]);
         end
      end
      tick();
   endtask

   task automatic test_hyst();
      bus.pc_if = 32'h300;
      drive_upd(32'h300, 32'h3000, 1'b0);
      tick();
      bus.upd_en = 1'b0;
      #1;
      checks++;
      if (bus.hit_if !== 1'b0) begin
         errors++;
         $display("FAIL not_taken_hit got=%b want=0", bus.hit_if);
      end
      drive_upd(32'h300, 32'h3400, 1'b1);
      tick();
      bus.upd_en = 1'b0;
      #1;
      checks++;
      if (bus.hit_if !== 1'b1 || bus.target_if !== 32'h3400) begin
         errors++;
         $display("FAIL retaken_hit got=%b/%h want=1/00003400", bus.hit_if, bus.target_if);
      end
   endtask

   task automatic test_random();
      int          sets [3] = '{8'h40, 8'h41, 5};
      bit          eh;
      logic [31:0] et;
      for (int c = 0; c < 700; c++) begin
         bus.pc_if = (32'($urandom_range(0, 5)) << 9) | (32'(sets[$urandom_range(0, 2)]) << 2)
                     | 32'($urandom_range(0, 3));
         bus.upd_en     = ($urandom_range(0, 2) != 0);
         bus.upd_pc     = (32'($urandom_range(0, 5)) << 9) | (32'(sets[$urandom_range(0, 2)]) << 2);
         bus.upd_target = $urandom & 32'hffff_fffc;
         bus.upd_taken  = ($urandom_range(0, 3) != 0);
         bus.flush_req  = ($urandom_range(0, 299) == 0);
         #3;
         m_lookup(bus.pc_if, eh, et);
         checks++;
         if (bus.hit_if !== eh || bus.target_if !== et) begin
            errors++;
            $display("FAIL rand_lookup c=%0d pc=%h got=%b/%h want=%b/%h", c, bus.pc_if, bus.hit_if, bus.target_if, eh, et);
         end
         checks++;
         if (bus.flush_busy !== (m_busy > 0)) begin
            errors++;
            $display("FAIL rand_busy c=%0d got=%b want=%b", c, bus.flush_busy, m_busy > 0);
         end
         tick();
      end
      bus.upd_en    = 1'b0;
      bus.flush_req = 1'b0;
      for (int c = 0; c < SETS + 2 && m_busy > 0; c++) tick();
   endtask

   task automatic test_flush();
      int          busy_cycles;
      logic [31:0] pcs [3] = '{32'h100, 32'h300, 32'h700};
      busy_cycles = 0;
      drive_upd(32'h100, 32'h2000, 1'b1);
      tick();
      drive_upd(32'h300, 32'h3000, 1'b1);
      tick();
      bus.upd_en    = 1'b0;
      bus.flush_req = 1'b1;
      tick();
      bus.flush_req = 1'b0;
      for (int c = 0; c < SETS + 4; c++) begin
         bus.pc_if = c[0] ? 32'h300 : 32'h100;
         if (c == 50) drive_upd(32'h700, 32'h7000, 1'b1);
         else         bus.upd_en = 1'b0;
         #3;
         if (bus.flush_busy === 1'b1) busy_cycles++;
         checks++;
         if (bus.flush_busy !== (c < SETS)) begin
            errors++;
            $display("FAIL sweep_busy c=%0d got=%b want=%b", c, bus.flush_busy, c < SETS);
         end
         if (c < SETS) begin
            checks++;
            if (bus.hit_if !== 1'b0) begin
               errors++;
               $display("FAIL sweep_hit c=%0d got=%b want=0", c, bus.hit_if);
            end
         end
         tick();
      end
      bus.upd_en = 1'b0;
      checks++;
      if (busy_cycles != SETS) begin
         errors++;
         $display("FAIL sweep_len got=%0d want=%0d", busy_cycles, SETS);
      end
      for (int i = 0; i < 3; i++) begin
         bus.pc_if = pcs[i];
         #1;
         checks++;
         if (bus.hit_if !== 1'b0 || bus.target_if !== 32'd0) begin
            errors++;
            $display("FAIL post_flush_%h got=%b/%h want=0/00000000", pcs[i], bus.hit_if, bus.target_if);
         end
      end
   endtask

   task automatic test_reset_sweep();
      drive_upd(32'h100, 32'h2000, 1'b1);
      tick();
      bus.upd_en    = 1'b0;
      bus.flush_req = 1'b1;
      tick();
      bus.flush_req = 1'b0;
      repeat (40) tick();
      #2;
      rst_n = 1'b0;
      #1;
      m_clear();
      m_busy = 0;
      checks++;
      if (bus.flush_busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_busy got=%b want=0", bus.flush_busy);
      end
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      bus.pc_if = 32'h100;
      #1;
      checks++;
      if (bus.hit_if !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_miss got=%b want=0", bus.hit_if);
      end
      drive_upd(32'h100, 32'h1234, 1'b1);
      tick();
      bus.upd_en = 1'b0;
      #1;
      checks++;
      if (bus.hit_if !== 1'b1 || bus.target_if !== 32'h1234) begin
         errors++;
         $display("FAIL rst_mid_realloc got=%b/%h want=1/00001234", bus.hit_if, bus.target_if);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_evict();
      test_hyst();
      test_random();
      test_flush();
      test_reset_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
